// File: rtl/systolic_matmul_nxn.sv
// N x N output-stationary systolic matrix multiplier: C = A x B over unsigned operands.
// A streams in from the left and B from the top, both skewed; each PE keeps one C element.
module systolic_matmul_nxn_pe #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    output logic [AW-1:0] acc
);
    // Only the low AW bits of the full product can reach the wrapping accumulator.
    logic [AW-1:0] prod;
    assign prod = AW'(a_in) * AW'(b_in);

    always_ff @(posedge clk) begin
        if (rst || clr) acc <= '0;
        else if (en)    acc <= acc + prod;
    end
endmodule

module systolic_matmul_nxn #(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N*N*DW-1:0] a_flat,
    input  logic [N*N*DW-1:0] b_flat,
    output logic              busy,
    output logic              done,
    output logic [N*N*AW-1:0] c_flat
);
    localparam int TW = $clog2(3*N-2);
    localparam logic [TW-1:0] TLAST = TW'(3*N-3);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t state, nxt;

    logic [TW-1:0]                    t;
    logic [N-1:0][N-1:0][DW-1:0]      a_reg, b_reg;
    logic [N-1:0][N-2:0][DW-1:0]      a_pipe;
    logic [N-2:0][N-1:0][DW-1:0]      b_pipe;
    logic [N-1:0][N-1:0][DW-1:0]      a_in_v, b_in_v;
    logic [N-1:0][N-1:0][AW-1:0]      acc_all, c_reg;
    logic                             busy_d, done_d, c_ld;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (start) nxt = LOAD;
            LOAD: nxt = RUN;
            RUN:  if (t == TLAST) nxt = DONE;
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_d = (nxt == LOAD) || (nxt == RUN);
        done_d = (state == DONE);
        c_ld   = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            c_reg <= '0;
        end else begin
            busy <= busy_d;
            done <= done_d;
            if (c_ld) c_reg <= acc_all;
        end
    end
    assign c_flat = c_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            t     <= '0;
            a_reg <= '0;
            b_reg <= '0;
        end else if (state == LOAD) begin
            t     <= '0;
            a_reg <= a_flat;
            b_reg <= b_flat;
        end else if (state == RUN) begin
            t <= t + TW'(1);
        end
    end

    // Edge injection uses skew k = t - row (A) / k = t - col (B); interior inputs come from the hop registers.
    always_comb begin
        a_in_v = '0;
        b_in_v = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                if (int'(t) == i + k) begin
                    a_in_v[i][0] = a_reg[i][k];
                    b_in_v[0][i] = b_reg[k][i];
                end
            end
            for (int j = 1; j < N; j++) begin
                a_in_v[i][j] = a_pipe[i][j-1];
                b_in_v[j][i] = b_pipe[j-1][i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state == LOAD) begin
            a_pipe <= '0;
            b_pipe <= '0;
        end else if (state == RUN) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N-1; j++) begin
                    a_pipe[i][j] <= a_in_v[i][j];
                    b_pipe[j][i] <= b_in_v[j][i];
                end
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            systolic_matmul_nxn_pe #(.DW(DW), .AW(AW)) u_pe (
                .clk  (clk),
                .rst  (rst),
                .clr  (state == LOAD),
                .en   (state == RUN),
                .a_in (a_in_v[i][j]),
                .b_in (b_in_v[i][j]),
                .acc  (acc_all[i][j])
            );
        end
    end
endmodule

// File: tb/tb_systolic_matmul_nxn.sv
// Directed bench: four configurations (N=2/3/4, narrow 8/16 variant) checked against hand-computed results.
module tb_systolic_matmul_nxn;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic start2, start4, startb, start3;
    logic busy2, busy4, busyb, busy3;
    logic done2, done4, doneb, done3;
    logic [1:0][1:0][31:0] a2, b2, c2, exp2;
    logic [3:0][3:0][31:0] a4, b4, c4, exp4;
    logic [1:0][1:0][7:0]  ab, bb;
    logic [1:0][1:0][15:0] cb, expb;
    logic [2:0][2:0][31:0] a3, b3, c3, exp3a, exp3b;

    systolic_matmul_nxn #(.N(2), .DW(32), .AW(32)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a_flat(a2), .b_flat(b2),
        .busy(busy2), .done(done2), .c_flat(c2));
    systolic_matmul_nxn #(.N(4), .DW(32), .AW(32)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a_flat(a4), .b_flat(b4),
        .busy(busy4), .done(done4), .c_flat(c4));
    systolic_matmul_nxn #(.N(2), .DW(8), .AW(16)) dutb (
        .clk(clk), .rst(rst), .start(startb), .a_flat(ab), .b_flat(bb),
        .busy(busyb), .done(doneb), .c_flat(cb));
    systolic_matmul_nxn #(.N(3), .DW(32), .AW(32)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .a_flat(a3), .b_flat(b3),
        .busy(busy3), .done(done3), .c_flat(c3));

    task automatic test_reset();
        rst = 1'b1;
        start2 = 0; start4 = 0; startb = 0; start3 = 0;
        a2 = '0; b2 = '0; a4 = '0; b4 = '0; ab = '0; bb = '0; a3 = '0; b3 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total += 4;
        if ({busy2, busy4, busyb, busy3} !== 4'b0) begin bad++; $display("FAIL reset_busy got=%b want=0000", {busy2, busy4, busyb, busy3}); end
        if ({done2, done4, doneb, done3} !== 4'b0) begin bad++; $display("FAIL reset_done got=%b want=0000", {done2, done4, doneb, done3}); end
        if (c2 !== '0 || cb !== '0) begin bad++; $display("FAIL reset_c_n2 got=%h/%h want=0", c2, cb); end
        if (c4 !== '0 || c3 !== '0) begin bad++; $display("FAIL reset_c_n4n3 got=%h/%h want=0", c4, c3); end
    endtask

    // Start coincides with the first edge where rst is low.
    task automatic test_basic_n2();
        int busy_n = 0;
        rst = 1'b0;
        a2[0][0] = 1; a2[0][1] = 2; a2[1][0] = 0; a2[1][1] = 2;
        b2 = a2;
        exp2[0][0] = 1; exp2[0][1] = 6; exp2[1][0] = 0; exp2[1][1] = 4;
        start2 = 1'b1;
        @(posedge clk);
        for (int s = 0; s <= 9; s++) begin
            @(negedge clk);
            if (s == 0) start2 = 1'b0;
            if (s == 1) begin a2 = '0; b2 = '0; end
            busy_n += int'(busy2);
            total++;
            if (done2 !== (s == 6)) begin bad++; $display("FAIL basic_done s=%0d got=%b want=%b", s, done2, s == 6); end
            if (s == 5) begin total++; if (c2 !== '0) begin bad++; $display("FAIL basic_c_hold got=%h want=0", c2); end end
            if (s == 6 || s == 9) begin total++; if (c2 !== exp2) begin bad++; $display("FAIL basic_c s=%0d got=%h want=%h", s, c2, exp2); end end
        end
        total++;
        if (busy_n != 5) begin bad++; $display("FAIL basic_busy_len got=%0d want=5", busy_n); end
    endtask

    task automatic test_identity_n4();
        int busy_n = 0;
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                a4[i][j] = (i == j) ? 32'd1 : 32'd0;
                b4[i][j] = 32'(4*i + j + 1);
                exp4[i][j] = 32'(4*i + j + 1);
            end
        start4 = 1'b1;
        @(posedge clk);
        for (int s = 0; s <= 14; s++) begin
            @(negedge clk);
            if (s == 0) start4 = 1'b0;
            busy_n += int'(busy4);
            total++;
            if (done4 !== (s == 12)) begin bad++; $display("FAIL ident_done s=%0d got=%b want=%b", s, done4, s == 12); end
        end
        total += 2;
        if (busy_n != 11) begin bad++; $display("FAIL ident_busy_len got=%0d want=11", busy_n); end
        if (c4 !== exp4) begin bad++; $display("FAIL ident_c got=%h want=%h", c4, exp4); end
    endtask

    task automatic test_wrap_n2();
        @(negedge clk);
        ab = {4{8'd255}};
        bb = {4{8'd255}};
        expb = {4{16'd64514}};
        startb = 1'b1;
        @(posedge clk);
        for (int s = 0; s <= 7; s++) begin
            @(negedge clk);
            if (s == 0) startb = 1'b0;
            total++;
            if (doneb !== (s == 6)) begin bad++; $display("FAIL wrap_done s=%0d got=%b want=%b", s, doneb, s == 6); end
        end
        total++;
        if (cb !== expb) begin bad++; $display("FAIL wrap_c got=%h want=%h", cb, expb); end
    endtask

    task automatic test_ignore_start_n2();
        int dones = 0;
        @(negedge clk);
        a2 = {4{32'd1}};
        b2[0][0] = 1; b2[0][1] = 0; b2[1][0] = 0; b2[1][1] = 1;
        exp2 = {4{32'd1}};
        start2 = 1'b1;
        @(posedge clk);
        for (int s = 0; s <= 12; s++) begin
            @(negedge clk);
            if (s == 0) start2 = 1'b0;
            if (s == 1) begin a2 = {4{32'd5}}; b2 = {4{32'd7}}; start2 = 1'b1; end
            if (s == 2) start2 = 1'b0;
            dones += int'(done2);
            if (s == 6) begin total++; if (done2 !== 1'b1) begin bad++; $display("FAIL ign_done_at6 got=%b want=1", done2); end end
        end
        total += 3;
        if (dones != 1) begin bad++; $display("FAIL ign_done_count got=%0d want=1", dones); end
        if (c2 !== exp2) begin bad++; $display("FAIL ign_c got=%h want=%h", c2, exp2); end
        if (busy2 !== 1'b0) begin bad++; $display("FAIL ign_busy_end got=%b want=0", busy2); end
    endtask

    // Abort at RUN step t=5 (sample 6), then rerun with A = 2I so C = 2B.
    task automatic test_reset_midrun_n4();
        int dones = 0;
        @(negedge clk);
        start4 = 1'b1;
        @(posedge clk);
        for (int s = 0; s <= 16; s++) begin
            @(negedge clk);
            if (s == 0) start4 = 1'b0;
            dones += int'(done4);
            if (s == 6) begin
                total++;
                if (c4 !== exp4) begin bad++; $display("FAIL abort_c_held got=%h want=%h", c4, exp4); end
                rst = 1'b1;
            end
            if (s == 7) begin
                rst = 1'b0;
                total += 2;
                if (busy4 !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy4); end
                if (c4 !== '0) begin bad++; $display("FAIL abort_c_clear got=%h want=0", c4); end
            end
        end
        total++;
        if (dones != 0) begin bad++; $display("FAIL abort_done_count got=%0d want=0", dones); end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                a4[i][j] = (i == j) ? 32'd2 : 32'd0;
                exp4[i][j] = 32'(2 * (4*i + j + 1));
            end
        start4 = 1'b1;
        @(posedge clk);
        for (int s = 0; s <= 13; s++) begin
            @(negedge clk);
            if (s == 0) start4 = 1'b0;
            total++;
            if (done4 !== (s == 12)) begin bad++; $display("FAIL rerun_done s=%0d got=%b want=%b", s, done4, s == 12); end
        end
        total++;
        if (c4 !== exp4) begin bad++; $display("FAIL rerun_c got=%h want=%h", c4, exp4); end
    endtask

    task automatic test_back_to_back_n3();
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                a3[i][j] = (i == j) ? 32'd1 : 32'd0;
                b3[i][j] = 32'(3*i + j + 1);
                exp3a[i][j] = 32'(3*i + j + 1);
                exp3b[i][j] = 32'(2 * (3*i + j + 1));
            end
        start3 = 1'b1;
        @(posedge clk);
        for (int s = 0; s <= 22; s++) begin
            @(negedge clk);
            if (s == 1)  for (int i = 0; i < 3; i++) a3[i][i] = 32'd2;
            if (s == 11) for (int i = 0; i < 3; i++) a3[i][i] = 32'd3;
            total++;
            if (done3 !== (s == 9 || s == 19)) begin bad++; $display("FAIL b2b_done s=%0d got=%b want=%b", s, done3, s == 9 || s == 19); end
            if (s == 9)  begin total++; if (c3 !== exp3a) begin bad++; $display("FAIL b2b_c1 got=%h want=%h", c3, exp3a); end end
            if (s == 19) begin
                total++;
                if (c3 !== exp3b) begin bad++; $display("FAIL b2b_c2 got=%h want=%h", c3, exp3b); end
                start3 = 1'b0;
            end
        end
        total++;
        if (busy3 !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b want=0", busy3); end
    endtask

    initial begin
        test_reset();
        test_basic_n2();
        test_identity_n4();
        test_wrap_n2();
        test_ignore_start_n2();
        test_reset_midrun_n4();
        test_back_to_back_n3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/systolic_matmul_nxn.md
SYSTOLIC_MATMUL_NXN -- requirements
Module: systolic_matmul_nxn

Interface
REQ-001 Parameter: N, default 4, matrix dimension; legal range 2..8.
REQ-002 Parameter: DW, default 32, operand element width (unsigned).
REQ-003 Parameter: AW, default 32, accumulator and result element width (unsigned); AW >= DW.
REQ-004 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: start  input  1  request to begin a multiply; sampled on the rising edge of clk.
REQ-007 Port: a_flat  input  N*N*DW  matrix A; element (i,j) at bits [(i*N+j)*DW +: DW].
REQ-008 Port: b_flat  input  N*N*DW  matrix B; same packing as a_flat.
REQ-009 Port: busy  output  1  high while an operation is in progress (LOAD or RUN).
REQ-010 Port: done  output  1  one-cycle pulse: c_flat has just been updated.
REQ-011 Port: c_flat  output  N*N*AW  result C = A x B; element (i,j) at bits [(i*N+j)*AW +: AW].

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, RUN and DONE, with registered outputs busy, done and c_flat.
REQ-013 In IDLE with start=1, the next state SHALL be LOAD; with start=0, the FSM SHALL remain in IDLE.
REQ-014 In LOAD (1 cycle), the block SHALL capture a_flat/b_flat into internal operand registers, clear all N*N PE accumulators, and clear the step counter t; a_flat/b_flat may change afterwards without effect.
REQ-015 RUN SHALL last exactly 3N-2 cycles, t = 0..3N-3; RUN -> DONE when t = 3N-3.
REQ-016 Skewed feed: at step t, row i of the left edge SHALL inject A(i,k) with k = t-i when 0 <= k < N, else 0; column j of the top edge SHALL inject B(k,j) with k = t-j when 0 <= k < N, else 0.
REQ-017 Each PE(i,j) SHALL register its a input to PE(i,j+1) and its b input to PE(i+1,j), one cycle per hop, and SHALL accumulate acc += a*b every RUN cycle.
REQ-018 The product SHALL be the DW x DW unsigned full-width product; accumulation SHALL wrap modulo 2^AW, with no saturation and no overflow flag.
REQ-019 On entry to DONE, c_flat SHALL load all accumulators, done SHALL be 1 for exactly that one cycle, and the next state SHALL be IDLE.
REQ-020 c_flat SHALL hold its value until the next DONE; it SHALL NOT change during LOAD or RUN.
REQ-021 Latency SHALL be fixed at 3N cycles: a start sampled at edge E gives done=1 in the cycle after edge E+3N (N=2: done high in the 6th cycle after the start edge).
REQ-022 busy SHALL be 1 in LOAD and RUN, and 0 in IDLE and DONE.
REQ-023 start SHALL be ignored in LOAD, RUN and DONE; no queuing. A start held high through DONE SHALL be accepted in the following IDLE cycle.
REQ-024 Throughput: at most one operation per 3N+1 cycles.

Reset
REQ-025 With rst=1 at a rising edge, the FSM SHALL go to IDLE, and busy, done, t, all accumulators, pipeline registers and c_flat SHALL be 0.
REQ-026 rst SHALL take priority over start and over every state, including mid-RUN; the aborted operation SHALL produce no done and no c_flat update.
REQ-027 The first start SHALL be accepted on the first edge with rst=0.

Verification
REQ-028 N=2, DW=AW=32, A=[[1,2],[0,2]], B=[[1,2],[0,2]], start pulse -> done 1 cycle, exactly 6 cycles after the start edge, C=[[1,6],[0,4]].
REQ-029 N=4, A=identity, B(i,j)=4i+j+1, start -> C=B, with busy high for exactly 3N-1=11 cycles.
REQ-030 N=2, DW=8, AW=16, all A and B elements 255 -> every C element = 130050 mod 65536 = 64514.
REQ-031 N=2: start again at busy cycle 2 with different operands -> ignored; result matches the first operands only, with a single done.
REQ-032 N=4: rst asserted at RUN step t=5, then new start -> no done for the aborted operation, c_flat=0 after reset, and the second result is correct.
REQ-033 N=3: start held high continuously -> back-to-back operations with a done every 3N+1=10 cycles; operands changed after LOAD do not affect the result.
